// File: rtl/router_pkg.sv
// Shared types for the 4-way router datapath: destination address, beat layout
// and the output-stage occupancy states.
package router_pkg;

  localparam int NUM_DEST         = 4;
  localparam int ROUTE_DATA_WIDTH = 32;

  typedef logic [1:0] dest_addr_t;

  typedef struct packed {
    dest_addr_t                  addr;
    logic [ROUTE_DATA_WIDTH-1:0] data;
  } route_beat_t;

  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request after the pointer.
// Latency: combinational grant; the pointer moves to the winner on advance.
// Backpressure: the pointer holds whenever advance is low, so stalls never rotate priority.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Walk pointer+1 .. pointer+N (mod N); the first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      sum = {1'b0, ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr <= IW'(N-1);
    else if (advance) ptr <= gnt_idx;
  end

endmodule

// File: rtl/router_arbiter.sv
// Shares one 4-destination router stage between NUM_REQ round-robin requesters.
// Latency: 1 cycle from requester handshake to destination valid; full rate back-to-back.
// Backpressure: only the held destination's ready can free the stage; otherwise all req_ready are 0.
module router_arbiter
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_addr,
  output logic [DATA_WIDTH-1:0]         dout0,
  output logic [DATA_WIDTH-1:0]         dout1,
  output logic [DATA_WIDTH-1:0]         dout2,
  output logic [DATA_WIDTH-1:0]         dout3,
  output logic [NUM_DEST-1:0]           dout_valid,
  input  logic [NUM_DEST-1:0]           dout_ready,
  output logic [IW-1:0]                 grant_id
);

  typedef struct packed {
    dest_addr_t            addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  occ_state_t            state, state_nxt;
  beat_t                 held, win_beat;
  beat_t                 beat_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] dout_arr [NUM_DEST];
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  held_rdy, can_load, hs;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_arr[i].addr = req_addr[i*2 +: 2];
      beat_arr[i].data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign win_beat = beat_arr[gnt_idx];

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req_valid),
    .advance (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Muxing by the registered addr keeps non-held destination readies off the accept path.
  assign held_rdy  = dout_ready[held.addr];
  assign can_load  = (state == OCC_EMPTY) || held_rdy;
  assign req_ready = can_load ? gnt : '0;
  assign hs        = can_load && (|req_valid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= OCC_EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OCC_EMPTY: if (hs) state_nxt = OCC_FULL;
      OCC_FULL:  if (held_rdy && !hs) state_nxt = OCC_EMPTY;
      default:   state_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held     <= '0;
      grant_id <= '0;
    end else if (hs) begin
      held     <= win_beat;
      grant_id <= gnt_idx;
    end
  end

  always_comb begin
    dout_valid = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      dout_arr[k] = '0;
      if ((state == OCC_FULL) && (held.addr == dest_addr_t'(k))) begin
        dout_valid[k] = 1'b1;
        dout_arr[k]   = held.data;
      end
    end
  end

  assign dout0 = dout_arr[0];
  assign dout1 = dout_arr[1];
  assign dout2 = dout_arr[2];
  assign dout3 = dout_arr[3];

endmodule

// File: tb/tb_router_arbiter.sv
// Scenario bench for router_arbiter: a reference model predicts every handshake,
// pushes the expected beat, and the output side pops and compares it.
module tb_router_arbiter;

  logic         clk, resetn;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_data;
  logic [7:0]   req_addr;
  logic [31:0]  dout0, dout1, dout2, dout3;
  logic [3:0]   dout_valid, dout_ready;
  logic [1:0]   grant_id;

  router_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_addr(req_addr),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [1:0] addr;
    logic [31:0] data;
  } sb_t;

  int          checks = 0;
  int          failures = 0;
  sb_t         exp_q[$];
  bit          m_full;
  int          m_ptr;
  logic [1:0]  m_addr;
  int          hs_idx;
  bit          drained;
  logic [31:0] obs_drain;
  int          sent, recv;

  function automatic int rr_pick(int ptr, logic [3:0] v);
    for (int off = 1; off <= 4; off++) begin
      if (v[(ptr + off) % 4]) return (ptr + off) % 4;
    end
    return -1;
  endfunction

  task automatic set_beat(input int i, input logic [1:0] a, input logic [31:0] d);
    req_data[i*32 +: 32] = d;
    req_addr[i*2 +: 2]   = a;
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 3;
    m_addr = 2'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    req_valid  = 4'b0;
    dout_ready = 4'hF;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // One cycle: check accept and output side against the model, then advance it.
  task automatic tick();
    logic [3:0]   er, ev;
    logic [127:0] ed, od;
    int           w;
    bit           can;
    sb_t          b;
    #1;
    can = !m_full || dout_ready[m_addr];
    w   = rr_pick(m_ptr, req_valid);
    er  = (can && w >= 0) ? (4'b1 << w) : 4'b0;
    checks++;
    if (req_ready !== er) begin
      failures++;
      $display("FAIL req_ready actual=%b required=%b t=%0t", req_ready, er, $time);
    end
    ev = m_full ? (4'b1 << m_addr) : 4'b0;
    checks++;
    if (dout_valid !== ev) begin
      failures++;
      $display("FAIL dout_valid actual=%b required=%b t=%0t", dout_valid, ev, $time);
    end
    od = {dout3, dout2, dout1, dout0};
    if (m_full && exp_q.size() > 0) begin
      ed = '0;
      ed[int'(m_addr)*32 +: 32] = exp_q[0].data;
      checks++;
      if (od !== ed) begin
        failures++;
        $display("FAIL dout_data actual=%h required=%h t=%0t", od, ed, $time);
      end
      checks++;
      if (grant_id !== 2'(exp_q[0].id)) begin
        failures++;
        $display("FAIL grant_id actual=%0d required=%0d t=%0t", grant_id, exp_q[0].id, $time);
      end
    end
    drained = 1'b0;
    hs_idx  = -1;
    if (m_full && dout_ready[m_addr]) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      obs_drain = od[int'(m_addr)*32 +: 32];
      drained   = 1'b1;
      recv++;
      m_full = 1'b0;
    end
    if (can && w >= 0) begin
      b.id   = w;
      b.addr = req_addr[w*2 +: 2];
      b.data = req_data[w*32 +: 32];
      exp_q.push_back(b);
      m_full = 1'b1;
      m_addr = b.addr;
      m_ptr  = w;
      hs_idx = w;
      sent++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dout_valid, grant_id} !== 6'b0 || {dout3, dout2, dout1, dout0} !== 128'b0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b/%0d required=0/0", dout_valid, grant_id);
    end
    do_reset();
    set_beat(0, 2'd2, 32'hCAFE_0002);
    req_valid  = 4'b0001;
    dout_ready = 4'b1011;
    tick();
    req_valid = 4'b0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 4'b0 || dout2 !== 32'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL async_reset actual=%b/%h/%0d required=0000/0/0", dout_valid, dout2, grant_id);
    end
    model_reset();
    @(negedge clk);
    resetn     = 1'b1;
    dout_ready = 4'hF;
    tick();
    checks++;
    if (dout_valid !== 4'b0 || dout2 !== 32'b0) begin
      failures++;
      $display("FAIL stale_after_reset actual=%b/%h required=0000/0", dout_valid, dout2);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    set_beat(1, 2'd3, 32'hA5A5_0001);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_ready actual=%b required=0010", req_ready);
    end
    tick();
    req_valid = 4'b0;
    checks++;
    if (dout_valid !== 4'b1000 || dout3 !== 32'hA5A5_0001 || grant_id !== 2'd1 ||
        {dout2, dout1, dout0} !== 96'b0) begin
      failures++;
      $display("FAIL single_out actual=%b/%h/%0d required=1000/a5a50001/1",
               dout_valid, dout3, grant_id);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [1:0] cur_addr [4];
    logic [1:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cur_addr[i] = 2'(i);
      set_beat(i, cur_addr[i], {4'(i), 12'd0, 16'hF00D});
    end
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      a = cur_addr[c % 4];
      tick();
      if (hs_idx >= 0) begin
        cur_addr[hs_idx] = 2'($urandom_range(3, 0));
        set_beat(hs_idx, cur_addr[hs_idx], {4'(hs_idx), 12'(c + 1), 16'hF00D});
      end
      checks++;
      if (grant_id !== 2'(c % 4) || dout_valid !== (4'b1 << a)) begin
        failures++;
        $display("FAIL fair_seq c=%0d actual=%0d/%b required=%0d/%b",
                 c, grant_id, dout_valid, c % 4, 4'b1 << a);
      end
    end
    req_valid = 4'b0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set_beat(0, 2'd0, 32'h0000_5A5A);
    req_valid = 4'b0001;
    tick();
    dout_ready = 4'b1110;
    set_beat(0, 2'd2, 32'h1111_0000);
    set_beat(1, 2'd3, 32'h1111_0001);
    set_beat(2, 2'd1, 32'h1111_0002);
    set_beat(3, 2'd0, 32'h1111_0003);
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0 || dout0 !== 32'h0000_5A5A || grant_id !== 2'd0) begin
        failures++;
        $display("FAIL stall_hold c=%0d actual=%b/%h/%0d required=0000/00005a5a/0",
                 c, req_ready, dout0, grant_id);
      end
      tick();
    end
    dout_ready = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL stall_release actual=%b required=0010", req_ready);
    end
    tick();
    checks++;
    if (grant_id !== 2'd1 || dout3 !== 32'h1111_0001) begin
      failures++;
      $display("FAIL stall_next actual=%0d/%h required=1/11110001", grant_id, dout3);
    end
    req_valid = 4'b0;
    tick();
  endtask

  task automatic test_drain_load();
    do_reset();
    set_beat(1, 2'd1, 32'hD1D1_0001);
    req_valid = 4'b0010;
    tick();
    set_beat(2, 2'd1, 32'hD2D2_0002);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL drain_load_ready actual=%b required=0100", req_ready);
    end
    tick();
    req_valid = 4'b0;
    checks++;
    if (dout_valid !== 4'b0010 || dout1 !== 32'hD2D2_0002 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL drain_load_out actual=%b/%h/%0d required=0010/d2d20002/2",
               dout_valid, dout1, grant_id);
    end
    tick();
  endtask

  task automatic test_wrap_sparse();
    do_reset();
    set_beat(3, 2'd0, 32'h3333_0000);
    req_valid = 4'b1000;
    tick();
    set_beat(3, 2'd1, 32'h3333_0001);
    set_beat(0, 2'd2, 32'h0000_0002);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_ready0 actual=%b required=0001", req_ready);
    end
    tick();
    set_beat(0, 2'd3, 32'h0000_0003);
    checks++;
    if (grant_id !== 2'd0 || dout2 !== 32'h0000_0002) begin
      failures++;
      $display("FAIL wrap_grant0 actual=%0d/%h required=0/00000002", grant_id, dout2);
    end
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_ready3 actual=%b required=1000", req_ready);
    end
    tick();
    req_valid = 4'b0;
    checks++;
    if (grant_id !== 2'd3 || dout1 !== 32'h3333_0001) begin
      failures++;
      $display("FAIL wrap_grant3 actual=%0d/%h required=3/33330001", grant_id, dout1);
    end
    tick();
  endtask

  task automatic test_random();
    bit pend [4];
    int nseq [4];
    int rseq [4];
    int src, seq, lost;
    do_reset();
    sent = 0;
    recv = 0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; nseq[i] = 0; rseq[i] = 0;
    end
    for (int c = 0; c < 340; c++) begin
      if (c < 300) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(1, 0) == 1) begin
            pend[i] = 1'b1;
            set_beat(i, 2'($urandom_range(3, 0)), {4'(i), 12'(nseq[i]), 16'($urandom)});
            nseq[i]++;
          end
        end
        dout_ready = 4'($urandom);
      end else begin
        dout_ready = 4'hF;
      end
      for (int i = 0; i < 4; i++) req_valid[i] = pend[i];
      tick();
      if (hs_idx >= 0) pend[hs_idx] = 1'b0;
      if (drained) begin
        src = int'(obs_drain[31:28]);
        seq = int'(obs_drain[27:16]);
        checks++;
        if (src > 3 || seq !== rseq[src % 4]) begin
          failures++;
          $display("FAIL rand_order src=%0d actual_seq=%0d required_seq=%0d",
                   src, seq, rseq[src % 4]);
        end
        rseq[src % 4]++;
      end
    end
    lost = 0;
    for (int i = 0; i < 4; i++) lost += nseq[i] - rseq[i];
    checks++;
    if (exp_q.size() != 0 || sent != recv || lost != 0) begin
      failures++;
      $display("FAIL rand_complete queue=%0d sent=%0d recv=%0d lost=%0d required=0/equal/0",
               exp_q.size(), sent, recv, lost);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 4'b0;
    req_data   = '0;
    req_addr   = '0;
    dout_ready = 4'hF;
    sent       = 0;
    recv       = 0;
    model_reset();
    test_reset();
    test_single_beat();
    test_fairness();
    test_stall();
    test_drain_load();
    test_wrap_sparse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
